// File: rtl/dual_ram_be.sv
// dual_ram_be: simple dual-port RAM with one write port and one read port on a single clock.
// Writes are byte-masked by w_strb. Read latency is 1 or 2 cycles (RD_LAT). A read and a write
// to the same in-range word in the same cycle return the new bytes for the enabled lanes and
// the old bytes for the rest. Reads beyond MEM_NUM return zero with r_err set.
// Optional macro DUAL_RAM_BE_INIT_CLR_EN adds a sequencer that zeroes every word after reset.
// While it runs, init_busy is high and all requests are ignored.
module dual_ram_be #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int MEM_NUM = 4096,
   parameter int RD_LAT  = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wen,
   input  logic [AW-1:0]     w_addr,
   input  logic [DW/8-1:0]   w_strb,
   input  logic [DW-1:0]     w_data,
   input  logic              ren,
   input  logic [AW-1:0]     r_addr,
   output logic [DW-1:0]     r_data,
   output logic              r_valid,
   output logic              r_err,
   output logic              init_busy
);

   localparam int          NB      = DW / 8;
   localparam int          IW      = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
   localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_NUM);

   generate
      if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
         $error("dual_ram_be: RD_LAT must be 1 or 2");
      end
      if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
         $error("dual_ram_be: DW must be a non-zero multiple of 8");
      end
   endgenerate

   // Replace the byte lanes selected by strb with the corresponding lanes of new_w
   function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] strb);
      logic [DW-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   logic [DW-1:0] mem [MEM_NUM];

   logic          clr_we;
   logic [IW-1:0] clr_idx;
   logic          w_inr, r_inr, wr_go, rd_go, col_p0;

   assign w_inr  = ({1'b0, w_addr} < MEM_LIM);
   assign r_inr  = ({1'b0, r_addr} < MEM_LIM);
   assign wr_go  = wen & ~init_busy & w_inr;
   assign rd_go  = ren & ~init_busy;
   assign col_p0 = wr_go & r_inr & (w_addr == r_addr);

`ifdef DUAL_RAM_BE_INIT_CLR_EN
   typedef enum logic {CLEAR, READY} clr_state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(MEM_NUM - 1);

   clr_state_t    state, state_nxt;
   logic [IW-1:0] cnt, cnt_nxt;

   // Sequencer state and clear-address counter; every reset restarts the walk at address 0
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Walk every address once, leaving CLEAR right after the last word is written
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == CLEAR) begin
         if (cnt == LAST_IDX) state_nxt = READY;
         else                 cnt_nxt   = cnt + IW'(1);
      end
   end

   // While clearing, write zero at the counter address and block the user ports
   always_comb begin
      init_busy = (state == CLEAR);
      clr_we    = (state == CLEAR);
      clr_idx   = cnt;
   end
`else
   assign init_busy = 1'b0;
   assign clr_we    = 1'b0;
   assign clr_idx   = '0;
`endif

   // Array write port: the clear sequencer and user writes never overlap in time
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (wr_go) begin
         for (int i = 0; i < NB; i++) begin
            if (w_strb[i]) mem[w_addr[IW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   // ---- stage p1: array read, plus the same-cycle write data for collision forwarding ----
   logic          vld_p1, err_p1, col_p1;
   logic [DW-1:0] rdat_p1, wdat_p1, merged_p1;
   logic [NB-1:0] wstb_p1;

   // Capture the read word and forwarding info only on accepted reads, so outputs hold otherwise
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
         col_p1  <= 1'b0;
         rdat_p1 <= '0;
         wdat_p1 <= '0;
         wstb_p1 <= '0;
      end else begin
         vld_p1 <= rd_go;
         if (rd_go) begin
            err_p1  <= ~r_inr;
            col_p1  <= col_p0;
            wdat_p1 <= w_data;
            wstb_p1 <= w_strb;
            rdat_p1 <= r_inr ? mem[r_addr[IW-1:0]] : '0;
         end
      end
   end

   assign merged_p1 = col_p1 ? lane_merge(rdat_p1, wdat_p1, wstb_p1) : rdat_p1;

   // ---- stage p2: optional extra output register ----
   generate
      if (RD_LAT == 2) begin : g_lat2
         logic          vld_p2, err_p2;
         logic [DW-1:0] dat_p2;

         // Delay the merged result one more cycle; data only loads when a read completes
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               vld_p2 <= 1'b0;
               err_p2 <= 1'b0;
               dat_p2 <= '0;
            end else begin
               vld_p2 <= vld_p1;
               err_p2 <= vld_p1 & err_p1;
               if (vld_p1) dat_p2 <= merged_p1;
            end
         end

         assign r_data  = dat_p2;
         assign r_valid = vld_p2;
         assign r_err   = err_p2;
      end else begin : g_lat1
         assign r_data  = merged_p1;
         assign r_valid = vld_p1;
         assign r_err   = vld_p1 & err_p1;
      end
   endgenerate

endmodule

// File: tb/tb_dual_ram_be.sv
// tb_dual_ram_be: drives one latency-1 and one latency-2 instance from shared inputs.
// A queue-based reference model predicts read results.
// With DUAL_RAM_BE_INIT_CLR_EN defined, the clear sequencer is exercised on a 16-word memory.
module tb_dual_ram_be;

   localparam int DW = 32;
   localparam int AW = 8;
`ifdef DUAL_RAM_BE_INIT_CLR_EN
   localparam int MN = 16;
   localparam bit EXP_IB = 1'b1;
`else
   localparam int MN = 100;
   localparam bit EXP_IB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn;
   logic          wen, ren;
   logic [AW-1:0] w_addr, r_addr;
   logic [3:0]    w_strb;
   logic [DW-1:0] w_data;
   logic [DW-1:0] rd1, rd2;
   logic          rv1, rv2, re1, re2, ib1, ib2;

   always #5 clk = ~clk;

   dual_ram_be #(.DW(DW), .AW(AW), .MEM_NUM(MN), .RD_LAT(1)) u_lat1 (
      .clk(clk), .rstn(rstn), .wen(wen), .w_addr(w_addr), .w_strb(w_strb), .w_data(w_data),
      .ren(ren), .r_addr(r_addr), .r_data(rd1), .r_valid(rv1), .r_err(re1), .init_busy(ib1));

   dual_ram_be #(.DW(DW), .AW(AW), .MEM_NUM(MN), .RD_LAT(2)) u_lat2 (
      .clk(clk), .rstn(rstn), .wen(wen), .w_addr(w_addr), .w_strb(w_strb), .w_data(w_data),
      .ren(ren), .r_addr(r_addr), .r_data(rd2), .r_valid(rv2), .r_err(re2), .init_busy(ib2));

   typedef struct { int due; logic [31:0] d; bit e; } rd_t;

   rd_t         q1[$], q2[$];
   logic [31:0] model_mem [MN];
   int          cyc, ntests, nfail;
   bit          model_busy;
   bit          exp_v1, exp_e1, exp_v2, exp_e2;
   logic [31:0] exp_d1, exp_d2;

   // One clock cycle: apply inputs, update the model, advance to the next falling edge
   task automatic tick(input bit we, input int wa, input logic [3:0] ws, input logic [31:0] wd,
                       input bit re, input int ra);
      rd_t         ent;
      logic [31:0] d;
      bit          e;
      wen = we; w_addr = AW'(wa); w_strb = ws; w_data = wd;
      ren = re; r_addr = AW'(ra);
      if (!model_busy) begin
         if (re) begin
            e = (ra >= MN);
            d = e ? 32'h0 : model_mem[ra];
            if (!e && we && wa == ra)
               for (int i = 0; i < 4; i++) if (ws[i]) d[8*i +: 8] = wd[8*i +: 8];
            ent.d = d; ent.e = e;
            ent.due = cyc + 1; q1.push_back(ent);
            ent.due = cyc + 2; q2.push_back(ent);
         end
         if (we && wa < MN)
            for (int i = 0; i < 4; i++) if (ws[i]) model_mem[wa][8*i +: 8] = wd[8*i +: 8];
      end
      @(posedge clk);
      cyc++;
      exp_v1 = 1'b0; exp_e1 = 1'b0; exp_v2 = 1'b0; exp_e2 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
         exp_v1 = 1'b1; exp_d1 = q1[0].d; exp_e1 = q1[0].e; void'(q1.pop_front());
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
         exp_v2 = 1'b1; exp_d2 = q2[0].d; exp_e2 = q2[0].e; void'(q2.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic idle();
      tick(1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); @(negedge clk); end
   endtask

   task automatic reset_assert();
      rstn = 1'b0;
      wen = 1'b0; ren = 1'b0; w_addr = '0; r_addr = '0; w_strb = '0; w_data = '0;
      q1.delete(); q2.delete();
      exp_v1 = 1'b0; exp_e1 = 1'b0; exp_d1 = '0;
      exp_v2 = 1'b0; exp_e2 = 1'b0; exp_d2 = '0;
`ifdef DUAL_RAM_BE_INIT_CLR_EN
      for (int a = 0; a < MN; a++) model_mem[a] = 32'h0;
`endif
   endtask

   task automatic reset_release();
      rstn = 1'b1;
      model_busy = EXP_IB;
   endtask

   task automatic test_reset();
      reset_assert();
      idle_cycles(2);
      ntests++; if (rv1 !== 1'b0) begin nfail++; $display("FAIL reset_rv1: got %b want 0", rv1); end
      ntests++; if (rv2 !== 1'b0) begin nfail++; $display("FAIL reset_rv2: got %b want 0", rv2); end
      ntests++; if (re1 !== 1'b0) begin nfail++; $display("FAIL reset_re1: got %b want 0", re1); end
      ntests++; if (re2 !== 1'b0) begin nfail++; $display("FAIL reset_re2: got %b want 0", re2); end
      ntests++; if (rd1 !== 32'h0) begin nfail++; $display("FAIL reset_rd1: got %h want 0", rd1); end
      ntests++; if (rd2 !== 32'h0) begin nfail++; $display("FAIL reset_rd2: got %h want 0", rd2); end
      ntests++; if (ib1 !== EXP_IB) begin nfail++; $display("FAIL reset_ib1: got %b want %b", ib1, EXP_IB); end
      ntests++; if (ib2 !== EXP_IB) begin nfail++; $display("FAIL reset_ib2: got %b want %b", ib2, EXP_IB); end
      reset_release();
      idle();
      ntests++; if (ib1 !== EXP_IB) begin nfail++; $display("FAIL post_reset_ib1: got %b want %b", ib1, EXP_IB); end
`ifdef DUAL_RAM_BE_INIT_CLR_EN
      repeat (MN - 1) idle();
      model_busy = 1'b0;
`endif
   endtask

`ifdef DUAL_RAM_BE_INIT_CLR_EN
   task automatic test_init_clear();
      int busy_cnt;
      for (int pass = 0; pass < 2; pass++) begin
         reset_assert();
         idle_cycles(2);
         reset_release();
         if (pass == 1) begin
            repeat (8) idle();
            reset_assert();
            idle_cycles(1);
            reset_release();
         end
         busy_cnt = 0;
         for (int k = 0; k < 3 * MN && ib1 === 1'b1; k++) begin
            busy_cnt++;
            ntests++;
            if (rv1 !== 1'b0 || rv2 !== 1'b0) begin
               nfail++; $display("FAIL clear_rvalid: got %b/%b want 0/0", rv1, rv2);
            end
            tick(1'b1, k % MN, 4'hF, 32'hFFFF_FFFF, 1'b1, k % MN);
         end
         model_busy = 1'b0;
         ntests++; if (busy_cnt !== MN) begin nfail++; $display("FAIL clear_len: got %0d want %0d", busy_cnt, MN); end
         ntests++; if (ib2 !== 1'b0) begin nfail++; $display("FAIL clear_ib2: got %b want 0", ib2); end
         ntests++;
         if (rv1 !== 1'b0 || rv2 !== 1'b0) begin
            nfail++; $display("FAIL clear_tail_rvalid: got %b/%b want 0/0", rv1, rv2);
         end
      end
      for (int a = 0; a < MN; a++) begin
         tick(1'b0, 0, 4'h0, 32'h0, 1'b1, a);
         ntests++;
         if (rv1 !== 1'b1 || rd1 !== 32'h0) begin
            nfail++; $display("FAIL clear_zero[%0d]: got v=%b d=%h want v=1 d=0", a, rv1, rd1);
         end
      end
      idle(); idle();
   endtask
`endif

   task automatic test_fill();
      for (int a = 0; a < MN; a++) tick(1'b1, a, 4'hF, $urandom, 1'b0, 0);
      idle();
   endtask

   task automatic test_basic();
      tick(1'b1, 5, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
      tick(1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
      ntests++; if (rv1 !== 1'b1) begin nfail++; $display("FAIL basic_rv1: got %b want 1", rv1); end
      ntests++; if (rd1 !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL basic_rd1: got %h want deadbeef", rd1); end
      ntests++; if (re1 !== 1'b0) begin nfail++; $display("FAIL basic_re1: got %b want 0", re1); end
      ntests++; if (rv2 !== 1'b0) begin nfail++; $display("FAIL basic_rv2_early: got %b want 0", rv2); end
      idle();
      ntests++; if (rv1 !== 1'b0) begin nfail++; $display("FAIL basic_pulse1: got %b want 0", rv1); end
      ntests++; if (rd1 !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL basic_hold1: got %h want deadbeef", rd1); end
      ntests++; if (rv2 !== 1'b1) begin nfail++; $display("FAIL basic_rv2: got %b want 1", rv2); end
      ntests++; if (rd2 !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL basic_rd2: got %h want deadbeef", rd2); end
      idle();
      ntests++; if (rv2 !== 1'b0) begin nfail++; $display("FAIL basic_pulse2: got %b want 0", rv2); end
   endtask

   task automatic test_partial();
      tick(1'b1, 5, 4'b0101, 32'h1122_3344, 1'b0, 0);
      tick(1'b1, 5, 4'b0000, 32'h9999_9999, 1'b1, 5);
      ntests++;
      if (rv1 !== 1'b1 || rd1 !== 32'hDE22_BE44) begin
         nfail++; $display("FAIL partial_rd1: got v=%b d=%h want v=1 d=de22be44", rv1, rd1);
      end
      idle();
      ntests++;
      if (rv2 !== 1'b1 || rd2 !== 32'hDE22_BE44) begin
         nfail++; $display("FAIL partial_rd2: got v=%b d=%h want v=1 d=de22be44", rv2, rd2);
      end
   endtask

   task automatic test_collision();
      tick(1'b1, 9, 4'hF, 32'hAAAA_AAAA, 1'b0, 0);
      tick(1'b1, 9, 4'b0011, 32'h1234_5678, 1'b1, 9);
      ntests++;
      if (rv1 !== 1'b1 || rd1 !== 32'hAAAA_5678) begin
         nfail++; $display("FAIL coll_rd1: got v=%b d=%h want v=1 d=aaaa5678", rv1, rd1);
      end
      tick(1'b0, 0, 4'h0, 32'h0, 1'b1, 9);
      ntests++;
      if (rv2 !== 1'b1 || rd2 !== 32'hAAAA_5678) begin
         nfail++; $display("FAIL coll_rd2: got v=%b d=%h want v=1 d=aaaa5678", rv2, rd2);
      end
      ntests++; if (rd1 !== 32'hAAAA_5678) begin nfail++; $display("FAIL coll_stored1: got %h want aaaa5678", rd1); end
      tick(1'b1, 9, 4'hF, 32'hFFFF_FFFF, 1'b0, 0);
      ntests++;
      if (rv2 !== 1'b1 || rd2 !== 32'hAAAA_5678) begin
         nfail++; $display("FAIL late_write_rd2: got v=%b d=%h want v=1 d=aaaa5678", rv2, rd2);
      end
      tick(1'b0, 0, 4'h0, 32'h0, 1'b1, 9);
      ntests++; if (rd1 !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL coll_after_rd1: got %h want ffffffff", rd1); end
      idle();
   endtask

   task automatic test_out_of_range();
      int          k;
      logic [31:0] prev;
      k = (MN > 50) ? 50 : MN / 2;
      tick(1'b0, 0, 4'h0, 32'h0, 1'b1, MN);
      ntests++;
      if (rv1 !== 1'b1 || re1 !== 1'b1 || rd1 !== 32'h0) begin
         nfail++; $display("FAIL oor_1: got v=%b e=%b d=%h want v=1 e=1 d=0", rv1, re1, rd1);
      end
      idle();
      ntests++;
      if (rv2 !== 1'b1 || re2 !== 1'b1 || rd2 !== 32'h0) begin
         nfail++; $display("FAIL oor_2: got v=%b e=%b d=%h want v=1 e=1 d=0", rv2, re2, rd2);
      end
      ntests++; if (re1 !== 1'b0) begin nfail++; $display("FAIL oor_err_idle1: got %b want 0", re1); end
      prev = model_mem[k];
      tick(1'b1, MN + k, 4'hF, ~prev, 1'b0, 0);
      tick(1'b0, 0, 4'h0, 32'h0, 1'b1, k);
      ntests++;
      if (rv1 !== 1'b1 || rd1 !== prev) begin
         nfail++; $display("FAIL oor_write_dropped: got v=%b d=%h want v=1 d=%h", rv1, rd1, prev);
      end
      idle(); idle();
   endtask

   task automatic test_stream();
      logic [31:0] expv [4];
      for (int i = 0; i < 4; i++) expv[i] = model_mem[i];
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 0, 4'h0, 32'h0, i < 4, i);
         ntests++;
         if (i < 4) begin
            if (rv1 !== 1'b1 || rd1 !== expv[i]) begin
               nfail++; $display("FAIL stream1[%0d]: got v=%b d=%h want v=1 d=%h", i, rv1, rd1, expv[i]);
            end
         end else if (rv1 !== 1'b0) begin
            nfail++; $display("FAIL stream1[%0d]: got v=%b want 0", i, rv1);
         end
         ntests++;
         if (i >= 1 && i <= 4) begin
            if (rv2 !== 1'b1 || rd2 !== expv[i-1]) begin
               nfail++; $display("FAIL stream2[%0d]: got v=%b d=%h want v=1 d=%h", i, rv2, rd2, expv[i-1]);
            end
         end else if (rv2 !== 1'b0) begin
            nfail++; $display("FAIL stream2[%0d]: got v=%b want 0", i, rv2);
         end
      end
   endtask

   task automatic test_random();
      bit we, re;
      int wa, ra;
      for (int n = 0; n < 402; n++) begin
         we = (n < 400) && ($urandom_range(0, 1) == 1);
         re = (n < 400) && ($urandom_range(0, 3) != 0);
         wa = $urandom_range(0, MN + 3);
         ra = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, MN + 3);
         tick(we, wa, 4'($urandom), $urandom, re, ra);
         ntests++;
         if (rv1 !== exp_v1 || re1 !== exp_e1 || rd1 !== exp_d1) begin
            nfail++;
            $display("FAIL rand1[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     n, rv1, re1, rd1, exp_v1, exp_e1, exp_d1);
         end
         ntests++;
         if (rv2 !== exp_v2 || re2 !== exp_e2 || rd2 !== exp_d2) begin
            nfail++;
            $display("FAIL rand2[%0d]: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                     n, rv2, re2, rd2, exp_v2, exp_e2, exp_d2);
         end
      end
   endtask

   task automatic test_reset_midstream();
      tick(1'b0, 0, 4'h0, 32'h0, 1'b1, 0);
      tick(1'b0, 0, 4'h0, 32'h0, 1'b1, 1);
      reset_assert();
      #1;
      ntests++;
      if (rv1 !== 1'b0 || rv2 !== 1'b0) begin
         nfail++; $display("FAIL midrst_async: got %b/%b want 0/0", rv1, rv2);
      end
      @(negedge clk);
      idle_cycles(1);
      reset_release();
      for (int i = 0; i < 4; i++) begin
         idle();
         ntests++;
         if (rv1 !== 1'b0 || rv2 !== 1'b0) begin
            nfail++; $display("FAIL midrst_after[%0d]: got %b/%b want 0/0", i, rv1, rv2);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      cyc = 0; ntests = 0; nfail = 0; model_busy = 1'b0;
      rstn = 1'b0;
      test_reset();
`ifdef DUAL_RAM_BE_INIT_CLR_EN
      test_init_clear();
`endif
      test_fill();
      test_basic();
      test_partial();
      test_collision();
      test_out_of_range();
      test_stream();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
